// File: rtl/vga_pattern_pkg.sv
// vga_pattern_pkg: shared definitions for the VGA test-pattern generator.
//   - default 640x480@60 timing constants (pixels / lines)
//   - pattern id enum matching the 2-bit PIO pattern-select register
//   - colour-bar masks: bit k set means that channel is full-scale in bar k
package vga_pattern_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int COLOR_W_DEF  = 4;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_CHECK = 2'd1,
      PAT_RAMP  = 2'd2,
      PAT_GRID  = 2'd3
   } pat_e;

   // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [7:0] BAR_R_MASK = 8'b0011_0011;
   localparam logic [7:0] BAR_G_MASK = 8'b0000_1111;
   localparam logic [7:0] BAR_B_MASK = 8'b0101_0101;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters and sync decode for the VGA pattern generator.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   pix_en          - pixel-advance enable; everything holds while low
//   h_cnt, v_cnt    - current pixel column / line (counter registers)
//   hs, vs          - registered active-low syncs for the counters of the
//                     previous pix_en cycle (aligned with the registered rgb)
//   active          - counters are inside the visible area (combinational)
//   at_origin       - counters sit at pixel (0,0) (combinational)
module vga_timing
   import vga_pattern_pkg::*;
#(
   parameter  int H_ACTIVE = H_ACTIVE_DEF,
   parameter  int H_FP     = H_FP_DEF,
   parameter  int H_SYNC   = H_SYNC_DEF,
   parameter  int H_BP     = H_BP_DEF,
   parameter  int V_ACTIVE = V_ACTIVE_DEF,
   parameter  int V_FP     = V_FP_DEF,
   parameter  int V_SYNC   = V_SYNC_DEF,
   parameter  int V_BP     = V_BP_DEF,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int H_W      = $clog2(H_TOTAL),
   localparam int V_W      = $clog2(V_TOTAL)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pix_en,
   output logic [H_W-1:0] h_cnt,
   output logic [V_W-1:0] v_cnt,
   output logic           hs,
   output logic           vs,
   output logic           active,
   output logic           at_origin
);

   localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

   logic hs_zone;
   logic vs_zone;

   assign hs_zone   = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_zone   = (v_cnt >= VS_START) && (v_cnt < VS_END);
   assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would chain counter and sync updates.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
         hs    <= 1'b1;
         vs    <= 1'b1;
      end else if (pix_en) begin
         // Syncs decode the counters before they advance, matching the rgb path.
         hs <= ~hs_zone;
         vs <= ~vs_zone;
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: 640x480@60 VGA timing plus four selectable test patterns.
// Ports:
//   clk, reset        - 50 MHz system clock, synchronous active-high reset
//   pix_en            - one-clk pixel-advance tick (25 MHz rate)
//   pat_id            - pattern select from the PIO register
//   vga_r/g/b         - registered colour to the DAC (0 outside active area)
//   vga_hs, vga_vs    - registered active-low syncs
//   frame_start       - one-clk pulse with pixel (0,0) on the outputs
//   cur_pat           - pattern being displayed this frame
// pat_id is only sampled at pixel (0,0), so a frame never mixes patterns.
module vga_pattern_gen
   import vga_pattern_pkg::*;
#(
   parameter  int H_ACTIVE = H_ACTIVE_DEF,
   parameter  int H_FP     = H_FP_DEF,
   parameter  int H_SYNC   = H_SYNC_DEF,
   parameter  int H_BP     = H_BP_DEF,
   parameter  int V_ACTIVE = V_ACTIVE_DEF,
   parameter  int V_FP     = V_FP_DEF,
   parameter  int V_SYNC   = V_SYNC_DEF,
   parameter  int V_BP     = V_BP_DEF,
   parameter  int COLOR_W  = COLOR_W_DEF,
   localparam int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   localparam int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_en,
   input  logic [1:0]         pat_id,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               frame_start,
   output logic [1:0]         cur_pat
);

   localparam logic [H_W-1:0]     H_ACT_LAST = H_W'(H_ACTIVE - 1);
   localparam logic [V_W-1:0]     V_ACT_LAST = V_W'(V_ACTIVE - 1);
   localparam logic [COLOR_W-1:0] FULL       = '1;

   logic [H_W-1:0]     h_cnt;
   logic [V_W-1:0]     v_cnt;
   logic               active;
   logic               at_origin;
   pat_e               cur_pat_q;
   pat_e               pix_pat;
   logic [2:0]         bar;
   logic [COLOR_W-1:0] r_d, g_d, b_d;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk       (clk),
      .reset     (reset),
      .pix_en    (pix_en),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .hs        (vga_hs),
      .vs        (vga_vs),
      .active    (active),
      .at_origin (at_origin)
   );

   // Pixel (0,0) is drawn with the select being latched on the same edge.
   assign pix_pat = at_origin ? pat_e'(pat_id) : cur_pat_q;
   assign cur_pat = cur_pat_q;

   // Bar index from a ladder of constant comparators (no divider).
   always_comb begin
      bar = '0;
      for (int k = 1; k < 8; k++) begin
         if (h_cnt >= H_W'(k * H_ACTIVE / 8)) bar = 3'(k);
      end
   end

   // NOTE: every always_comb output gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (active) begin
         case (pix_pat)
            PAT_BARS: begin
               r_d = {COLOR_W{BAR_R_MASK[bar]}};
               g_d = {COLOR_W{BAR_G_MASK[bar]}};
               b_d = {COLOR_W{BAR_B_MASK[bar]}};
            end
            PAT_CHECK: begin
               if (h_cnt[5] ^ v_cnt[5]) begin
                  r_d = FULL;
                  g_d = FULL;
                  b_d = FULL;
               end
            end
            PAT_RAMP: begin
               r_d = h_cnt[H_W-1 -: COLOR_W];
               g_d = h_cnt[H_W-1 -: COLOR_W];
               b_d = h_cnt[H_W-1 -: COLOR_W];
            end
            PAT_GRID: begin
               if (h_cnt == '0 || h_cnt == H_ACT_LAST ||
                   v_cnt == '0 || v_cnt == V_ACT_LAST) begin
                  r_d = FULL;
               end else if (h_cnt[4:0] == '0 || v_cnt[4:0] == '0) begin
                  r_d = FULL;
                  g_d = FULL;
                  b_d = FULL;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         frame_start <= 1'b0;
         cur_pat_q   <= PAT_BARS;
      end else if (pix_en) begin
         vga_r       <= r_d;
         vga_g       <= g_d;
         vga_b       <= b_d;
         frame_start <= at_origin;
         if (at_origin) cur_pat_q <= pat_e'(pat_id);
      end else begin
         // The pulse is one clk wide even when pix_en ticks every other clk.
         frame_start <= 1'b0;
      end
   end

endmodule
